ppu_mem_arbiter: RTL and testbench
==================================

# ppu_mem_arbiter

Shares the PPU's nibble-serial external RAM port (`addr_pins` out, `data_pins` in) between several internal fetch requesters: tile map, tile pixels, sprites and copper. It grants one requester per transaction with round-robin arbitration, shifts the 16-bit word address out MSB-first over `RAM_PINS` pins, and waits a fixed turnaround. It then assembles the 16-bit read word from `data_pins` and returns it to the granted requester. It sits inside the PPU between the fetch units and the top-level pin registers.

## Interface
Parameters:
- `RAM_PINS`, 4: width of address and data nibble buses; must divide 16.
- `NUM_REQ`, 3: number of requesters, 2..8.
- `LATENCY`, 2: cycles between the last address nibble and the first data nibble. Covers the top-level input/output pin registers plus RAM access.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, no new grants; an in-flight transaction completes.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_addr`  in  16*NUM_REQ: word addresses; requester i uses bits [16i+15:16i].
- `req_ready`  out  NUM_REQ: one-hot grant, combinational in IDLE. Handshake is `req_valid[i] && req_ready[i]`.
- `resp_valid`  out  NUM_REQ: one-hot, one-cycle pulse to the granted requester.
- `resp_data`  out  16: read word; valid only while `resp_valid` is nonzero, otherwise holds its last value.
- `addr_pins`  out  RAM_PINS: address nibble stream.
- `data_pins`  in  RAM_PINS: data nibble stream.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Let N = 16/RAM_PINS nibbles per word. N is 4 at the defaults.
- States: IDLE, ADDR, WAIT, DATA. A counter `cnt` tracks position within ADDR, WAIT and DATA.
- **IDLE:**
  - If `enable` is high and any `req_valid` is high, assert `req_ready` for the winner.
  - Latch its address and index, then go to ADDR with `cnt`=0.
  - `addr_pins`=0 in IDLE.
- **ADDR:** drive address nibble (N-1-cnt), MSB first. After cnt=N-1 go to WAIT, or directly to DATA if LATENCY=0.
- **WAIT:** `addr_pins`=0 for LATENCY cycles.
- **DATA:**
  - Sample `data_pins` each cycle, MSB nibble first, shifting into a 16-bit register.
  - After the N-th sample, register `resp_data` and set `resp_valid[sel]`=1 for the next cycle, then return to IDLE.
- **Round-robin:**
  - Register `last` holds the index of the last granted requester; reset value NUM_REQ-1.
  - Search order is last+1, last+2, …, wrapping modulo NUM_REQ. The first requester found with `req_valid` high wins.
  - `last` updates only on a grant.
- Requesters must hold `req_valid` and `req_addr` stable until granted. After grant they may drop or change them immediately.
- A requester may re-request while its own transaction is in flight. It is not granted before its `resp_valid`.
- **Reset mid-transaction:** return to IDLE, `last`=NUM_REQ-1. No `resp_valid` is issued for the aborted transaction.
- **`enable` low:**
  - Affects only the IDLE grant.
  - Dropping `enable` during ADDR, WAIT or DATA does not stall or abort the transaction.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `addr_pins`=0, `busy`=0, state IDLE.

## Timing
- Grant in cycle T (IDLE).
- Address nibbles on `addr_pins` in cycles T+1..T+N.
- Data nibbles sampled in cycles T+N+1+LATENCY..T+2N+LATENCY.
- `resp_valid` high in cycle T+2N+1+LATENCY, which is also an IDLE cycle. A new grant may occur in that same cycle.
- Transaction period: 2N+1+LATENCY cycles. At the defaults this is 11 cycles, grant to grant under continuous load.
- `addr_pins`, `resp_valid`, `resp_data` and `busy` are registered. `req_ready` is combinational from `req_valid`, `enable`, `last` and state.

## Structure
- Add to `ppu_common.vh`:
  - `PPU_MEM_ADDR_BITS` (16)
  - `PPU_MEM_DATA_BITS` (16)
  - state encodings `PPU_MEM_STATE_IDLE` / `_ADDR` / `_WAIT` / `_DATA`
- One sub-module, `rr_arbiter`. Parameter NUM_REQ. Inputs `req` and `last`; outputs one-hot `grant` and encoded `grant_idx`. Purely combinational.
- Sequencer, shift registers and counter live in `ppu_mem_arbiter`.

## Test plan
- **Single request:** req 1 with addr 0xA5C3 at T, `data_pins` nibbles 7,E,2,9.
  - Required: `addr_pins` A,5,C,3 in T+1..T+4.
  - Required: `resp_valid`=3'b010 with `resp_data`=0x7E29 at T+11.
- **All three requesting continuously from reset:** grants in order 0,1,2,0, spaced 11 cycles apart.
- **Simultaneous requests with `last`=0:** req 0 and 2 both valid; req 2 is granted first, then req 0.
- **`enable` low for 30 cycles with req 0 valid:** no grant while low. After `enable` rises, grant in the first IDLE cycle with `enable` high.
  - Dropping `enable` mid-ADDR still produces the `resp_valid` pulse.
- **Reset asserted during DATA:**
  - Next cycle: `busy`=0, `addr_pins`=0, and `resp_valid` stays 0.
  - After release, req 2 alone gets its grant at the first cycle.
- **LATENCY=0 build, single request:** `resp_valid` arrives 9 cycles after the grant.

Source files
------------

// File: rtl/ppu_mem_arbiter_pkg.sv
// ppu_mem_arbiter_pkg
// Shared constants and types for the PPU external-RAM arbiter: word widths,
// sequencer state encodings and a helper for nibbles per word.
package ppu_mem_arbiter_pkg;

  localparam int PPU_MEM_ADDR_BITS = 16;
  localparam int PPU_MEM_DATA_BITS = 16;

  typedef enum logic [1:0] {
    PPU_MEM_STATE_IDLE = 2'd0,
    PPU_MEM_STATE_ADDR = 2'd1,
    PPU_MEM_STATE_WAIT = 2'd2,
    PPU_MEM_STATE_DATA = 2'd3
  } ppu_mem_state_t;

  // Number of pin-width beats needed to move one 16-bit word.
  function automatic int nibbles_per_word(input int pins);
    return PPU_MEM_ADDR_BITS / pins;
  endfunction

endpackage

// File: rtl/ppu_mem_arbiter_if.sv
// ppu_mem_arbiter_if
// Bundle between the fetch requesters / RAM pins and the arbiter.
//   enable      : allow new grants
//   req_valid   : per-requester request
//   req_addr    : packed word addresses, requester i at [16i+15:16i]
//   req_ready   : one-hot grant
//   resp_valid  : one-hot response pulse
//   resp_data   : read word
//   addr_pins   : address nibble stream to RAM
//   data_pins   : data nibble stream from RAM
//   busy        : transaction in flight
// master = requester/pin side, slave = arbiter.
interface ppu_mem_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int RAM_PINS = 4
);
  import ppu_mem_arbiter_pkg::*;

  logic                                   enable;
  logic [NUM_REQ-1:0]                     req_valid;
  logic [PPU_MEM_ADDR_BITS*NUM_REQ-1:0]   req_addr;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ-1:0]                     resp_valid;
  logic [PPU_MEM_DATA_BITS-1:0]           resp_data;
  logic [RAM_PINS-1:0]                    addr_pins;
  logic [RAM_PINS-1:0]                    data_pins;
  logic                                   busy;

  modport master (
    output enable, req_valid, req_addr, data_pins,
    input  req_ready, resp_valid, resp_data, addr_pins, busy
  );

  modport slave (
    input  enable, req_valid, req_addr, data_pins,
    output req_ready, resp_valid, resp_data, addr_pins, busy
  );

endinterface

// File: rtl/ppu_mem_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: searches last+1, last+2, ... modulo
// NUM_REQ and returns the first active request.
//   i_req       : request vector
//   i_last      : index of the previously granted requester
//   o_grant     : one-hot winner (zero if no request)
//   o_grant_idx : encoded winner
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_last) + k) % NUM_REQ;
      // Inner constant-index loop keeps the selects statically sized.
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_idx) && i_req[j]) begin
          w_found     = 1'b1;
          o_grant[j]  = 1'b1;
          o_grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter
// Shares the nibble-serial external RAM port among NUM_REQ fetch units.
// One round-robin grant per transaction: address shifted out MSB-first,
// fixed LATENCY turnaround, then the read word is assembled from data_pins
// and returned with a one-cycle resp_valid pulse.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : requester / RAM pin bundle (slave side)
//
// state | meaning
// IDLE  | waiting for a request; req_ready asserted combinationally
// ADDR  | driving address nibbles, cnt = nibble position
// WAIT  | turnaround, addr_pins = 0, cnt counts LATENCY cycles
// DATA  | sampling data nibbles, cnt = nibble position
module ppu_mem_arbiter
  import ppu_mem_arbiter_pkg::*;
#(
  parameter int RAM_PINS = 4,
  parameter int NUM_REQ  = 3,
  parameter int LATENCY  = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  ppu_mem_arbiter_if.slave bus
);

  localparam int N     = nibbles_per_word(RAM_PINS);
  localparam int AW    = PPU_MEM_ADDR_BITS;
  localparam int DW    = PPU_MEM_DATA_BITS;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  ppu_mem_state_t      r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_sel;
  logic [AW-1:0]       r_addr_sh;
  logic [DW-1:0]       r_data_sh;
  logic [RAM_PINS-1:0] r_addr_pins;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DW-1:0]       r_resp_data;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [AW-1:0]       w_grant_addr;
  logic [DW-1:0]       w_data_next;
  logic                w_start;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req       (bus.req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_start       = (r_state == PPU_MEM_STATE_IDLE) && bus.enable && (|bus.req_valid);
  assign bus.req_ready = ((r_state == PPU_MEM_STATE_IDLE) && bus.enable) ? w_grant : '0;

  always_comb begin
    w_grant_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant_idx == IDX_W'(j)) w_grant_addr = bus.req_addr[j*AW +: AW];
    end
  end

  // Every transaction shifts in exactly N nibbles, so stale bits from the
  // previous word are always pushed out before the result is taken.
  assign w_data_next = (r_data_sh << RAM_PINS) | DW'(bus.data_pins);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= PPU_MEM_STATE_IDLE;
      r_cnt        <= '0;
      r_last       <= IDX_W'(NUM_REQ - 1);
      r_sel        <= '0;
      r_addr_sh    <= '0;
      r_data_sh    <= '0;
      r_addr_pins  <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        PPU_MEM_STATE_IDLE: begin
          if (w_start) begin
            r_last      <= w_grant_idx;
            r_sel       <= w_grant_idx;
            // First nibble goes out on the cycle right after the grant.
            r_addr_pins <= w_grant_addr[AW-1 -: RAM_PINS];
            r_addr_sh   <= w_grant_addr << RAM_PINS;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= PPU_MEM_STATE_ADDR;
          end
        end
        PPU_MEM_STATE_ADDR: begin
          if (r_cnt == CNT_W'(N - 1)) begin
            r_addr_pins <= '0;
            r_cnt       <= '0;
            r_state     <= (LATENCY == 0) ? PPU_MEM_STATE_DATA : PPU_MEM_STATE_WAIT;
          end else begin
            r_addr_pins <= r_addr_sh[AW-1 -: RAM_PINS];
            r_addr_sh   <= r_addr_sh << RAM_PINS;
            r_cnt       <= r_cnt + CNT_W'(1);
          end
        end
        PPU_MEM_STATE_WAIT: begin
          if (r_cnt == CNT_W'(LATENCY - 1)) begin
            r_cnt   <= '0;
            r_state <= PPU_MEM_STATE_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PPU_MEM_STATE_DATA: begin
          r_data_sh <= w_data_next;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_resp_data  <= w_data_next;
            r_resp_valid <= NUM_REQ'(1) << r_sel;
            r_busy       <= 1'b0;
            r_state      <= PPU_MEM_STATE_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= PPU_MEM_STATE_IDLE;
      endcase
    end
  end

  assign bus.addr_pins  = r_addr_pins;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter
// Directed bench for ppu_mem_arbiter: a default build (LATENCY=2) and a
// LATENCY=0 build sharing clock and reset.
module tb_ppu_mem_arbiter;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  ppu_mem_arbiter_if #(.NUM_REQ(3), .RAM_PINS(4)) bus  ();
  ppu_mem_arbiter_if #(.NUM_REQ(3), .RAM_PINS(4)) bus0 ();

  ppu_mem_arbiter #(.RAM_PINS(4), .NUM_REQ(3), .LATENCY(2)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  ppu_mem_arbiter #(.RAM_PINS(4), .NUM_REQ(3), .LATENCY(0)) u_dut_l0 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop requests and wait (bounded) for the arbiter to go idle.
  task automatic drain();
    bus.req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      tick();
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.addr_pins !== 4'h0 || bus.resp_valid !== 3'b000 ||
        bus.resp_data !== 16'h0000 || bus.req_ready !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b addr=%h rv=%b rd=%h rdy=%b want 0,0,000,0000,000",
               bus.busy, bus.addr_pins, bus.resp_valid, bus.resp_data, bus.req_ready);
    end
    tests_run++;
    if (bus0.busy !== 1'b0 || bus0.resp_valid !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs_l0: busy=%b rv=%b want 0,000", bus0.busy, bus0.resp_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] anib [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
    logic [3:0] dnib [4] = '{4'h7, 4'hE, 4'h2, 4'h9};
    bus.req_addr  = {16'h0000, 16'hA5C3, 16'h0000};
    bus.req_valid = 3'b010;
    #1;
    tests_run++;
    if (bus.req_ready !== 3'b010) begin
      fails++;
      $display("FAIL single_grant: req_ready=%b want 010", bus.req_ready);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.req_valid = '0;
      bus.data_pins = (k >= 7 && k <= 10) ? dnib[k-7] : 4'h0;
      #1;
      if (k <= 4) begin
        tests_run++;
        if (bus.addr_pins !== anib[k-1]) begin
          fails++;
          $display("FAIL single_addr_nib%0d: addr_pins=%h want %h", k, bus.addr_pins, anib[k-1]);
        end
      end
      if (k == 5) begin
        tests_run++;
        if (bus.addr_pins !== 4'h0 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL single_wait: addr_pins=%h busy=%b want 0,1", bus.addr_pins, bus.busy);
        end
      end
      if (k == 10) begin
        tests_run++;
        if (bus.resp_valid !== 3'b000) begin
          fails++;
          $display("FAIL single_early_resp: resp_valid=%b want 000", bus.resp_valid);
        end
      end
      if (k == 11) begin
        tests_run++;
        if (bus.resp_valid !== 3'b010 || bus.resp_data !== 16'h7E29 || bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL single_resp: rv=%b rd=%h busy=%b want 010,7e29,0",
                   bus.resp_valid, bus.resp_data, bus.busy);
        end
      end
    end
    bus.data_pins = 4'h0;
  endtask

  task automatic test_continuous();
    logic [2:0] g  [4];
    logic [2:0] rv [4];
    int         gc [4];
    int         n;
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    n = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.req_addr  = {16'h3333, 16'h2222, 16'h1111};
    bus.req_valid = 3'b111;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      #1;
      if (bus.req_ready !== 3'b000 && n < 4) begin
        g[n]  = bus.req_ready;
        rv[n] = bus.resp_valid;
        gc[n] = cyc;
        n++;
      end
      tick();
    end
    tests_run++;
    if (n != 4) begin
      fails++;
      $display("FAIL cont_grant_count: got %0d grants want 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (g[i] !== exp_g[i]) begin
          fails++;
          $display("FAIL cont_order%0d: grant=%b want %b", i, g[i], exp_g[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (gc[i] - gc[i-1] != 11 || rv[i] !== exp_g[i-1]) begin
            fails++;
            $display("FAIL cont_spacing%0d: gap=%0d rv=%b want 11,%b",
                     i, gc[i] - gc[i-1], rv[i], exp_g[i-1]);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    bus.req_addr  = {16'hCAFE, 16'h0000, 16'h1111};
    bus.req_valid = 3'b001;
    #1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.req_valid = (k == 11) ? 3'b101 : 3'b000;
      #1;
    end
    tests_run++;
    if (bus.req_ready !== 3'b100) begin
      fails++;
      $display("FAIL simul_first: req_ready=%b want 100", bus.req_ready);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.req_valid = 3'b001;
      #1;
      if (k == 6) begin
        tests_run++;
        if (bus.req_ready !== 3'b000) begin
          fails++;
          $display("FAIL simul_busy_ready: req_ready=%b want 000", bus.req_ready);
        end
      end
    end
    tests_run++;
    if (bus.req_ready !== 3'b001 || bus.resp_valid !== 3'b100) begin
      fails++;
      $display("FAIL simul_second: req_ready=%b rv=%b want 001,100", bus.req_ready, bus.resp_valid);
    end
    tick();
    drain();
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    bus.enable    = 1'b0;
    bus.req_addr  = {16'h0000, 16'h0000, 16'h0BAD};
    bus.req_valid = 3'b001;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.req_ready !== 3'b000 || bus.busy !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL enable_low_hold: %0d cycles with grant/busy want 0", bad);
    end
    bus.enable = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 3'b001) begin
      fails++;
      $display("FAIL enable_rise_grant: req_ready=%b want 001", bus.req_ready);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus.req_valid = '0;
      if (k == 2) bus.enable = 1'b0;
      #1;
    end
    tests_run++;
    if (bus.resp_valid !== 3'b001) begin
      fails++;
      $display("FAIL enable_drop_resp: resp_valid=%b want 001", bus.resp_valid);
    end
    bus.enable = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    bus.req_addr  = {16'h0000, 16'h5A5A, 16'h0000};
    bus.req_valid = 3'b010;
    #1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.req_valid = '0;
      bus.data_pins = 4'hF;
      if (k == 8) rst = 1'b1;
      #1;
    end
    tests_run++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_in_data: busy=%b want 1", bus.busy);
    end
    tick();
    rst = 1'b0;
    bus.data_pins = 4'h0;
    bus.req_addr  = {16'h4444, 16'h0000, 16'h0000};
    bus.req_valid = 3'b100;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.addr_pins !== 4'h0 || bus.resp_valid !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_after: busy=%b addr=%h rv=%b want 0,0,000",
               bus.busy, bus.addr_pins, bus.resp_valid);
    end
    tests_run++;
    if (bus.req_ready !== 3'b100) begin
      fails++;
      $display("FAIL rstmid_regrant: req_ready=%b want 100", bus.req_ready);
    end
    for (int k = 10; k <= 12; k++) begin
      tick();
      bus.req_valid = '0;
      #1;
      if (bus.resp_valid !== 3'b000) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rstmid_no_resp: %0d cycles with resp_valid want 0", bad);
    end
    drain();
  endtask

  task automatic test_latency0();
    logic [3:0] dnib [4] = '{4'hB, 4'hE, 4'hE, 4'hF};
    bus0.req_addr  = {16'h0000, 16'h1234, 16'h0000};
    bus0.req_valid = 3'b010;
    #1;
    tests_run++;
    if (bus0.req_ready !== 3'b010) begin
      fails++;
      $display("FAIL lat0_grant: req_ready=%b want 010", bus0.req_ready);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      bus0.req_valid = '0;
      bus0.data_pins = (k >= 5 && k <= 8) ? dnib[k-5] : 4'h0;
      #1;
      if (k == 4) begin
        tests_run++;
        if (bus0.addr_pins !== 4'h4) begin
          fails++;
          $display("FAIL lat0_last_nib: addr_pins=%h want 4", bus0.addr_pins);
        end
      end
      if (k == 8) begin
        tests_run++;
        if (bus0.resp_valid !== 3'b000 || bus0.addr_pins !== 4'h0) begin
          fails++;
          $display("FAIL lat0_early: rv=%b addr=%h want 000,0", bus0.resp_valid, bus0.addr_pins);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (bus0.resp_valid !== 3'b010 || bus0.resp_data !== 16'hBEEF) begin
          fails++;
          $display("FAIL lat0_resp: rv=%b rd=%h want 010,beef", bus0.resp_valid, bus0.resp_data);
        end
      end
    end
    bus0.data_pins = 4'h0;
  endtask

  initial begin
    tests_run      = 0;
    fails          = 0;
    rst            = 1'b1;
    bus.enable     = 1'b1;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.data_pins  = '0;
    bus0.enable    = 1'b1;
    bus0.req_valid = '0;
    bus0.req_addr  = '0;
    bus0.data_pins = '0;

    test_reset();
    test_single();
    test_continuous();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    test_latency0();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
